unit_sequencer: RTL and testbench
=================================

UNIT_SEQUENCER -- requirements
Module: unit_sequencer

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 i_start  input  1  level; begins instruction fetch when in IDLE.
REQ-004 i_instruction  input  DATA_WIDTH  current IR contents from the register file.
REQ-005 i_cond  input  1  branch condition, sampled in MOVE when dst=PC and src=CR.
REQ-006 i_skin_ack  input  1  external memory accepted/served the request this cycle.
REQ-007 o_skin_req  output  1  external memory request, held high until ack.
REQ-008 o_skin_sel  output  2  skin port select: 0=code fetch (oen[12]), 1=oen[13], 2=oen[14].
REQ-009 o_unit_oen  output  16  one-hot source enable onto data bus.
REQ-010 o_unit_ien  output  16  one-hot destination load enable.
REQ-011 o_busy  output  1  high in any state except IDLE and HALT.
REQ-012 o_halted  output  1  high in HALT.
REQ-013 o_err  output  1  one-cycle pulse on illegal instruction.

Function
REQ-014 Unit index map: 1=IR, 2=PC, 3=AR, 4=DR0, 5=DR1, 6=CR, 12..14=skin sources.
REQ-015 Instruction fields: src=IR[3:0], dst=IR[7:4]; all other bits ignored.
REQ-016 States: IDLE, FETCH, DECODE, MOVE, SKIN, HALT; the encoding is local.
REQ-017 IDLE->FETCH when i_start=1; otherwise stay in IDLE with all outputs 0.
REQ-018 FETCH: o_skin_req=1, o_skin_sel=0; in the cycle i_skin_ack=1, oen[12]=1 and ien[1]=1 for exactly that one cycle, then go to DECODE.
REQ-019 oen[12] SHALL never be high for more than one cycle per fetch, so PC increments exactly once.
REQ-020 DECODE (one cycle, IR valid): register src/dst; all enables 0.
REQ-021 DECODE transitions: src=dst=15 -> HALT; src=dst=0 (NOP) -> FETCH; src in {13,14} with dst in {1..6} -> SKIN; src in {1..6} with dst in {1..6} and src!=dst -> MOVE; src=4 with dst=4 -> MOVE (DR0 increment); else pulse o_err, -> FETCH.
REQ-022 MOVE: one cycle with oen[src]=1 and ien[dst]=1, then -> FETCH.
REQ-023 MOVE with src=6, dst=2: assert ien[2] only if i_cond=1; oen[6] is always asserted.
REQ-024 SKIN: o_skin_req=1, o_skin_sel=src-12; in the ack cycle pulse oen[src] and ien[dst] for one cycle, then -> FETCH.
REQ-025 Waiting in FETCH or SKIN is unbounded; enables stay 0 while ack=0.
REQ-026 HALT is terminal until reset; i_start is ignored there.
REQ-027 At most one oen bit and one ien bit are high in any cycle.
REQ-028 Enables and o_skin_req are decoded combinationally from registered state, registered src/dst, i_skin_ack and i_cond; no other combinational input-to-output paths exist.

Reset
REQ-029 rst=1 forces IDLE and clears src/dst; all outputs read 0 during reset.
REQ-030 Reset during FETCH or SKIN drops o_skin_req immediately; an ack arriving during reset is ignored.

Structure
REQ-031 Unit index constants (INDEX_EN_*) and DATA_WIDTH come from the shared define header; state codes are local parameters.
REQ-032 Single module with no sub-modules; the optional one-hot decoder is a function inside it.

Verification
REQ-033 start=1, ack on 3rd FETCH cycle, IR=0x43 -> oen[12]/ien[1] pulse once; next MOVE cycle oen=0x0008, ien=0x0010.
REQ-034 IR=0x26, i_cond=0 -> MOVE oen=0x0040, ien=0x0000; repeat with i_cond=1 -> ien=0x0004.
REQ-035 IR=0x5D, ack after 4 cycles -> o_skin_sel=1 held; single-cycle oen=0x2000, ien=0x0020.
REQ-036 IR=0x1F (illegal) -> o_err pulses one cycle, no enables, return to FETCH.
REQ-037 IR=0xFF -> HALT, o_halted=1, o_busy=0; i_start ignored.
REQ-038 rst asserted mid-SKIN with ack high -> o_skin_req=0, enables 0 same cycle, IDLE after release.

Source files
------------

// File: rtl/unit_sequencer_pkg.sv
// rtl/unit_sequencer_pkg.sv - shared data width and unit index constants for the sequencer
package unit_sequencer_pkg;

  localparam int DATA_WIDTH = 16;

  typedef logic [3:0] unit_idx_t;

  localparam unit_idx_t INDEX_EN_IR    = 4'd1;
  localparam unit_idx_t INDEX_EN_PC    = 4'd2;
  localparam unit_idx_t INDEX_EN_AR    = 4'd3;
  localparam unit_idx_t INDEX_EN_DR0   = 4'd4;
  localparam unit_idx_t INDEX_EN_DR1   = 4'd5;
  localparam unit_idx_t INDEX_EN_CR    = 4'd6;
  localparam unit_idx_t INDEX_EN_SKIN0 = 4'd12;
  localparam unit_idx_t INDEX_EN_SKIN1 = 4'd13;
  localparam unit_idx_t INDEX_EN_SKIN2 = 4'd14;

endpackage

// File: rtl/unit_sequencer.sv
// rtl/unit_sequencer.sv - fetch/decode/move sequencer driving one-hot bus enables
module unit_sequencer
  import unit_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_instruction,
  input  logic                  i_cond,
  input  logic                  i_skin_ack,
  output logic                  o_skin_req,
  output logic [1:0]            o_skin_sel,
  output logic [15:0]           o_unit_oen,
  output logic [15:0]           o_unit_ien,
  output logic                  o_busy,
  output logic                  o_halted,
  output logic                  o_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MOVE   = 3'd3;
  localparam logic [2:0] S_SKIN   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0] state, next_state;
  unit_idx_t  src, dst;
  unit_idx_t  ir_src, ir_dst;
  unit_idx_t  sel_full;
  logic       err_q, illegal;
  logic       unused_ir_hi;

  function automatic logic [15:0] onehot(input unit_idx_t idx);
    onehot = 16'h0001 << idx;
  endfunction

  function automatic logic is_reg(input unit_idx_t idx);
    is_reg = (idx >= INDEX_EN_IR) && (idx <= INDEX_EN_CR);
  endfunction

  assign ir_src       = i_instruction[3:0];
  assign ir_dst       = i_instruction[7:4];
  assign unused_ir_hi = ^i_instruction[DATA_WIDTH-1:8];

  always_comb begin
    next_state = state;
    illegal    = 1'b0;
    case (state)
      S_IDLE:   if (i_start) next_state = S_FETCH;
      S_FETCH:  if (i_skin_ack) next_state = S_DECODE;
      S_DECODE: begin
        if (ir_src == 4'd15 && ir_dst == 4'd15)
          next_state = S_HALT;
        else if (ir_src == 4'd0 && ir_dst == 4'd0)
          next_state = S_FETCH;
        else if ((ir_src == INDEX_EN_SKIN1 || ir_src == INDEX_EN_SKIN2) && is_reg(ir_dst))
          next_state = S_SKIN;
        else if (is_reg(ir_src) && is_reg(ir_dst) && ir_src != ir_dst)
          next_state = S_MOVE;
        else if (ir_src == INDEX_EN_DR0 && ir_dst == INDEX_EN_DR0)
          next_state = S_MOVE;
        else begin
          illegal    = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_MOVE:   next_state = S_FETCH;
      S_SKIN:   if (i_skin_ack) next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IDLE;
    endcase
  end

  // o_err is registered so the IR bus never reaches an output combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      src   <= '0;
      dst   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= next_state;
      err_q <= illegal;
      if (state == S_DECODE) begin
        src <= ir_src;
        dst <= ir_dst;
      end
    end
  end

  assign sel_full = src - INDEX_EN_SKIN0;

  always_comb begin
    o_skin_req = 1'b0;
    o_skin_sel = 2'd0;
    o_unit_oen = '0;
    o_unit_ien = '0;
    case (state)
      S_FETCH: begin
        o_skin_req = 1'b1;
        if (i_skin_ack) begin
          o_unit_oen = onehot(INDEX_EN_SKIN0);
          o_unit_ien = onehot(INDEX_EN_IR);
        end
      end
      S_MOVE: begin
        o_unit_oen = onehot(src);
        // conditional branch: CR is always driven, PC only loads when taken
        if (!(src == INDEX_EN_CR && dst == INDEX_EN_PC && !i_cond))
          o_unit_ien = onehot(dst);
      end
      S_SKIN: begin
        o_skin_req = 1'b1;
        o_skin_sel = sel_full[1:0];
        if (i_skin_ack) begin
          o_unit_oen = onehot(src);
          o_unit_ien = onehot(dst);
        end
      end
      default: ;
    endcase
  end

  assign o_busy   = (state != S_IDLE) && (state != S_HALT);
  assign o_halted = (state == S_HALT);
  assign o_err    = err_q;

endmodule

// File: tb/tb_unit_sequencer.sv
// tb/tb_unit_sequencer.sv - scoreboard bench for unit_sequencer
module tb_unit_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [15:0] i_instruction;
  logic        i_cond;
  logic        i_skin_ack;
  logic        o_skin_req;
  logic [1:0]  o_skin_sel;
  logic [15:0] o_unit_oen;
  logic [15:0] o_unit_ien;
  logic        o_busy;
  logic        o_halted;
  logic        o_err;

  typedef struct packed {
    logic [15:0] oen;
    logic [15:0] ien;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  unit_sequencer dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_instruction(i_instruction),
    .i_cond(i_cond), .i_skin_ack(i_skin_ack), .o_skin_req(o_skin_req),
    .o_skin_sel(o_skin_sel), .o_unit_oen(o_unit_oen), .o_unit_ien(o_unit_ien),
    .o_busy(o_busy), .o_halted(o_halted), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with an enable or error pulse consumes one expectation
  always @(negedge clk) begin
    if (!rst && (o_unit_oen != 16'h0 || o_unit_ien != 16'h0 || o_err)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: oen=0x%04h ien=0x%04h err=%0b with nothing expected",
                 o_unit_oen, o_unit_ien, o_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_oen", {16'h0, o_unit_oen}, {16'h0, e.oen});
        chk("event_ien", {16'h0, o_unit_ien}, {16'h0, e.ien});
        chk("event_err", {31'h0, o_err}, {31'h0, e.err});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at the first FETCH cycle; returns in the DECODE cycle
  task automatic fetch(input logic [15:0] ir, input int waits);
    i_instruction = ir;
    exp_q.push_back('{oen: 16'h1000, ien: 16'h0002, err: 1'b0});
    chk("fetch_req", {31'h0, o_skin_req}, 32'd1);
    chk("fetch_sel", {30'h0, o_skin_sel}, 32'd0);
    repeat (waits) step();
    i_skin_ack = 1'b1;
    step();
    i_skin_ack = 1'b0;
  endtask

  task automatic move(input logic [15:0] oen, input logic [15:0] ien);
    exp_q.push_back('{oen: oen, ien: ien, err: 1'b0});
    step();
    step();
  endtask

  task automatic skin(input int waits, input logic [1:0] sel,
                      input logic [15:0] oen, input logic [15:0] ien);
    step();
    exp_q.push_back('{oen: oen, ien: ien, err: 1'b0});
    repeat (waits) begin
      chk("skin_sel_hold", {30'h0, o_skin_sel}, {30'h0, sel});
      chk("skin_req_hold", {31'h0, o_skin_req}, 32'd1);
      step();
    end
    i_skin_ack = 1'b1;
    step();
    i_skin_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_start = 1'b0; i_instruction = 16'h0; i_cond = 1'b0; i_skin_ack = 1'b0;
    step();
    step();
    chk("reset_oen", {16'h0, o_unit_oen}, 32'h0);
    chk("reset_ien", {16'h0, o_unit_ien}, 32'h0);
    chk("reset_req", {31'h0, o_skin_req}, 32'd0);
    chk("reset_busy", {31'h0, o_busy}, 32'd0);
    chk("reset_halted", {31'h0, o_halted}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_busy", {31'h0, o_busy}, 32'd0);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("fetch_busy", {31'h0, o_busy}, 32'd1);

    fetch(16'h0043, 2);
    move(16'h0008, 16'h0010);

    i_cond = 1'b0;
    fetch(16'h0026, 0);
    move(16'h0040, 16'h0000);
    i_cond = 1'b1;
    fetch(16'h0026, 1);
    move(16'h0040, 16'h0004);
    i_cond = 1'b0;

    fetch(16'h0044, 0);
    move(16'h0010, 16'h0010);

    fetch(16'h0000, 1);
    step();

    fetch(16'h005D, 0);
    skin(4, 2'd1, 16'h2000, 16'h0020);

    fetch(16'h001F, 0);
    exp_q.push_back('{oen: 16'h0000, ien: 16'h0000, err: 1'b1});
    step();
    chk("err_back_to_fetch", {31'h0, o_skin_req}, 32'd1);
    step();

    fetch(16'h005E, 0);
    step();
    chk("skin2_sel", {30'h0, o_skin_sel}, 32'd2);
    chk("skin2_req", {31'h0, o_skin_req}, 32'd1);
    i_skin_ack = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mid_skin_req", {31'h0, o_skin_req}, 32'd0);
    chk("rst_mid_skin_oen", {16'h0, o_unit_oen}, 32'h0);
    chk("rst_mid_skin_ien", {16'h0, o_unit_ien}, 32'h0);
    step();
    i_skin_ack = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_busy", {31'h0, o_busy}, 32'd0);
    chk("post_rst_req", {31'h0, o_skin_req}, 32'd0);

    i_start = 1'b1;
    step();
    i_start = 1'b0;
    fetch(16'h00FF, 0);
    step();
    chk("halt_halted", {31'h0, o_halted}, 32'd1);
    chk("halt_busy", {31'h0, o_busy}, 32'd0);
    i_start = 1'b1;
    repeat (3) step();
    i_start = 1'b0;
    chk("halt_sticky", {31'h0, o_halted}, 32'd1);
    chk("halt_req", {31'h0, o_skin_req}, 32'd0);
    step();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
